spsram_fifo_ctrl: RTL and testbench

//  Upstream controller for the 32x32 single-port SRAM (spsram_doubled): turns a valid/ready

---
 rtl/spsram_fifo_ctrl_pkg.sv | 13 +
 rtl/spsram_fifo_ctrl_if.sv | 38 +++
 rtl/spsram_fifo_ctrl_head.sv | 27 ++
 rtl/spsram_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_spsram_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spsram_fifo_ctrl_pkg.sv
// Shared sizes and FSM state codes for the single-port-SRAM FIFO controller.
package spsram_fifo_ctrl_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RDWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/spsram_fifo_ctrl_if.sv
// Push/pop streams, status and SRAM command bus of the FIFO controller.
// master = controller view, slave = producer/consumer/SRAM view.
interface spsram_fifo_ctrl_if
  import spsram_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
);

  logic              i_push_valid;
  logic              o_push_ready;
  logic [DWIDTH-1:0] i_push_data;
  logic              o_pop_valid;
  logic              i_pop_ready;
  logic [DWIDTH-1:0] o_pop_data;
  logic [AWIDTH:0]   o_count;
  logic              o_full;
  logic              o_empty;
  logic [DWIDTH-1:0] o_mem_data;
  logic [AWIDTH-1:0] o_mem_addr;
  logic              o_mem_cen;
  logic              o_mem_wen;
  logic              o_mem_oen;
  logic [DWIDTH-1:0] i_mem_data;

  modport master (
    input  i_push_valid, i_push_data, i_pop_ready, i_mem_data,
    output o_push_ready, o_pop_valid, o_pop_data, o_count, o_full, o_empty,
           o_mem_data, o_mem_addr, o_mem_cen, o_mem_wen, o_mem_oen
  );

  modport slave (
    output i_push_valid, i_push_data, i_pop_ready, i_mem_data,
    input  o_push_ready, o_pop_valid, o_pop_data, o_count, o_full, o_empty,
           o_mem_data, o_mem_addr, o_mem_cen, o_mem_wen, o_mem_oen
  );

endinterface

// File: rtl/spsram_fifo_ctrl_head.sv
// One-word head register of the FIFO; load wins over clear.
// Latency: loaded word is visible the cycle after load.
module spsram_fifo_ctrl_head #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              clear,
  output logic              head_valid,
  output logic [DWIDTH-1:0] head_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (load) begin
      head_valid <= 1'b1;
      head_data  <= load_data;
    end else if (clear) begin
      head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spsram_fifo_ctrl.sv
// DEPTH+1 entry FIFO built on an external single-port SRAM plus a head register.
// Optional FIFO_BYPASS_EN: pushes into an empty FIFO load the head without an SRAM cycle.
module spsram_fifo_ctrl
  import spsram_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  spsram_fifo_ctrl_if.master bus
);

  if (DEPTH != (1 << AWIDTH)) begin : g_depth_chk
    $error("spsram_fifo_ctrl: DEPTH must equal 2**AWIDTH");
  end

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic              run;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   sram_cnt;
  logic              rd_inflight;
  logic              rd_issue;
  logic              bypass;
  logic              push_ready;
  logic              push_fire;
  logic              mem_wr;
  logic              pop_fire;
  logic              head_valid;
  logic [DWIDTH-1:0] head_data;
  logic              head_load;
  logic [DWIDTH-1:0] head_load_data;
  logic              mem_cen;
  logic              mem_wen;
  logic              mem_oen;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data;

  // Holds push_ready low while reset is asserted and for the first cycle after release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) run <= 1'b0;
    else         run <= 1'b1;
  end

  assign rd_inflight = (state == ST_RDWAIT);
  assign rd_issue    = !head_valid && !rd_inflight && (sram_cnt != '0);
  assign pop_fire    = head_valid && bus.i_pop_ready;

`ifdef FIFO_BYPASS_EN
  assign bypass = run && (sram_cnt == '0) && !rd_inflight && (!head_valid || pop_fire);
`else
  assign bypass = 1'b0;
`endif

  assign push_ready = run && (((sram_cnt != FULL_CNT) && !rd_issue) || bypass);
  assign push_fire  = bus.i_push_valid && push_ready;
  assign mem_wr     = push_fire && !bypass;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rd_issue) state_nxt = ST_RDWAIT;
      ST_RDWAIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Reads and writes are mutually exclusive, so the count moves by at most one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr   <= wr_ptr + AWIDTH'(1);
        sram_cnt <= sram_cnt + (AWIDTH+1)'(1);
      end else if (rd_issue) begin
        rd_ptr   <= rd_ptr + AWIDTH'(1);
        sram_cnt <= sram_cnt - (AWIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    mem_cen  = 1'b0;
    mem_wen  = 1'b0;
    mem_oen  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (rd_issue) begin
      mem_cen  = 1'b1;
      mem_oen  = 1'b1;
      mem_addr = rd_ptr;
    end else if (mem_wr) begin
      mem_cen  = 1'b1;
      mem_wen  = 1'b1;
      mem_addr = wr_ptr;
      mem_data = bus.i_push_data;
    end
  end

  assign head_load      = rd_inflight || (push_fire && bypass);
  assign head_load_data = rd_inflight ? bus.i_mem_data : bus.i_push_data;

  spsram_fifo_ctrl_head #(
    .DWIDTH (DWIDTH)
  ) u_head (
    .clk        (i_clk),
    .rst_n      (i_rstn),
    .load       (head_load),
    .load_data  (head_load_data),
    .clear      (pop_fire),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign bus.o_push_ready = push_ready;
  assign bus.o_pop_valid  = head_valid;
  assign bus.o_pop_data   = head_data;
  assign bus.o_count      = sram_cnt + (AWIDTH+1)'(rd_inflight) + (AWIDTH+1)'(head_valid);
  assign bus.o_full       = (sram_cnt == FULL_CNT);
  assign bus.o_empty      = (bus.o_count == '0);
  assign bus.o_mem_cen    = mem_cen;
  assign bus.o_mem_wen    = mem_wen;
  assign bus.o_mem_oen    = mem_oen;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_data   = mem_data;

endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// Directed bench for spsram_fifo_ctrl paired with a behavioural 32x32 single-port SRAM.
module tb_spsram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef FIFO_BYPASS_EN
  localparam int LAT_EXP = 0;
`else
  localparam int LAT_EXP = 2;
`endif

  logic i_clk = 1'b0;
  logic i_rstn;

  spsram_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  spsram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(32)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] mem_q = '0;
  always @(posedge i_clk) begin
    if (bus.o_mem_cen) begin
      if (bus.o_mem_wen)      mem[bus.o_mem_addr] <= bus.o_mem_data;
      else if (bus.o_mem_oen) mem_q <= mem[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_data = mem_q;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            acc;
  logic [DW-1:0] popped[$];
  int            pop_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes just before the edge, then returns 1ns after it.
  task automatic cycle();
    #1;
    acc = bus.i_push_valid && bus.o_push_ready;
    if (bus.o_pop_valid && bus.i_pop_ready) begin
      popped.push_back(bus.o_pop_data);
      pop_cyc.push_back(cyc);
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  initial begin
    int            nxt;
    int            bad;
    int            lat;
    logic [DW-1:0] first;

    i_rstn           = 1'b0;
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 32'hDEAD_BEEF;
    bus.i_pop_ready  = 1'b0;
    repeat (4) cycle();
    check("rst_empty",      64'(bus.o_empty),      64'd1);
    check("rst_count",      64'(bus.o_count),      64'd0);
    check("rst_cen",        64'(bus.o_mem_cen),    64'd0);
    check("rst_pop_valid",  64'(bus.o_pop_valid),  64'd0);
    check("rst_push_ready", 64'(bus.o_push_ready), 64'd0);
    check("rst_full",       64'(bus.o_full),       64'd0);
    check("rst_mem_data",   64'(bus.o_mem_data),   64'd0);
    check("rst_pop_data",   64'(bus.o_pop_data),   64'd0);

    i_rstn           = 1'b1;
    bus.i_push_valid = 1'b0;
    cycle();

    // Fill with no consumer: head plus 32 SRAM words.
    nxt = 0;
    for (int i = 0; i < 80; i++) begin
      bus.i_push_data  = 32'(nxt);
      bus.i_push_valid = (nxt <= 40);
      cycle();
      if (acc) nxt++;
    end
    check("fill_accepted",   64'(nxt),              64'd33);
    check("fill_full",       64'(bus.o_full),       64'd1);
    check("fill_count",      64'(bus.o_count),      64'd33);
    check("fill_pop_data",   64'(bus.o_pop_data),   64'd0);
    check("fill_pop_valid",  64'(bus.o_pop_valid),  64'd1);
    check("fill_push_ready", 64'(bus.o_push_ready), 64'd0);
    check("fill_cen_idle",   64'(bus.o_mem_cen),    64'd0);
    bus.i_push_valid = 1'b0;

    // Drain: full stays up until the refill read.
    popped.delete();
    pop_cyc.delete();
    bus.i_pop_ready = 1'b1;
    cycle();
    check("drain_full_hold", 64'(bus.o_full),    64'd1);
    check("drain_refill_cen", 64'(bus.o_mem_cen), 64'd1);
    check("drain_refill_oen", 64'(bus.o_mem_oen), 64'd1);
    check("drain_refill_wen", 64'(bus.o_mem_wen), 64'd0);
`ifndef FIFO_BYPASS_EN
    check("drain_refill_addr", 64'(bus.o_mem_addr), 64'd1);
`endif
    for (int i = 0; i < 200 && popped.size() < 33; i++) cycle();
    check("drain_pops", 64'(popped.size()), 64'd33);
    bad = 0;
    for (int k = 0; k < popped.size(); k++) if (popped[k] !== 32'(k)) bad++;
    check("drain_order", 64'(bad), 64'd0);
    bad = 0;
    for (int k = 1; k < pop_cyc.size(); k++) if (pop_cyc[k] - pop_cyc[k-1] != 3) bad++;
    check("drain_spacing", 64'(bad), 64'd0);
    check("drain_empty", 64'(bus.o_empty), 64'd1);
    check("drain_count", 64'(bus.o_count), 64'd0);

    // Random traffic across pointer wrap.
    popped.delete();
    pop_cyc.delete();
    nxt = 0;
    for (int i = 0; i < 3000 && popped.size() < 100; i++) begin
      bus.i_push_data  = 32'(nxt);
      bus.i_push_valid = (nxt < 100) && ($urandom_range(0, 3) != 0);
      bus.i_pop_ready  = ($urandom_range(0, 1) == 1);
      cycle();
      if (acc) nxt++;
    end
    bus.i_push_valid = 1'b0;
    bus.i_pop_ready  = 1'b0;
    check("wrap_pops", 64'(popped.size()), 64'd100);
    bad = 0;
    for (int k = 0; k < popped.size(); k++) if (popped[k] !== 32'(k)) bad++;
    check("wrap_order", 64'(bad), 64'd0);
    check("wrap_empty", 64'(bus.o_empty), 64'd1);

`ifndef FIFO_BYPASS_EN
    // Collision: pointers sit at 5 after 133 writes and reads.
    popped.delete();
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 32'h0000_0011;
    cycle();
    check("col_setup_acc", 64'(acc), 64'd1);
    bus.i_push_data = 32'hA5A5_A5A5;
    #1;
    check("col_push_ready", 64'(bus.o_push_ready), 64'd0);
    check("col_rd_cen",     64'(bus.o_mem_cen),    64'd1);
    check("col_rd_wen",     64'(bus.o_mem_wen),    64'd0);
    check("col_rd_oen",     64'(bus.o_mem_oen),    64'd1);
    check("col_rd_addr",    64'(bus.o_mem_addr),   64'd5);
    cycle();
    check("col_stall", 64'(acc), 64'd0);
    #1;
    check("col_wr_ready", 64'(bus.o_push_ready), 64'd1);
    check("col_wr_cen",   64'(bus.o_mem_cen),    64'd1);
    check("col_wr_wen",   64'(bus.o_mem_wen),    64'd1);
    check("col_wr_addr",  64'(bus.o_mem_addr),   64'd6);
    check("col_wr_data",  64'(bus.o_mem_data),   64'hA5A5_A5A5);
    cycle();
    check("col_wr_acc", 64'(acc), 64'd1);
    bus.i_push_valid = 1'b0;
    bus.i_pop_ready  = 1'b1;
    for (int i = 0; i < 30 && popped.size() < 2; i++) cycle();
    bus.i_pop_ready = 1'b0;
    check("col_pops", 64'(popped.size()), 64'd2);
    first = (popped.size() > 0) ? popped[0] : 'x;
    check("col_pop0", 64'(first), 64'h11);
    first = (popped.size() > 1) ? popped[1] : 'x;
    check("col_pop1", 64'(first), 64'hA5A5_A5A5);
`endif

    // Reset while a read is in flight.
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 32'h77;
    cycle();
    bus.i_push_valid = 1'b0;
    cycle();
    i_rstn = 1'b0;
    #1;
    check("mrst_count",      64'(bus.o_count),      64'd0);
    check("mrst_empty",      64'(bus.o_empty),      64'd1);
    check("mrst_pop_valid",  64'(bus.o_pop_valid),  64'd0);
    check("mrst_cen",        64'(bus.o_mem_cen),    64'd0);
    check("mrst_push_ready", 64'(bus.o_push_ready), 64'd0);
    check("mrst_pop_data",   64'(bus.o_pop_data),   64'd0);
    repeat (2) cycle();
    i_rstn = 1'b1;
    cycle();
    check("mrst_post_empty", 64'(bus.o_empty), 64'd1);

    popped.delete();
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 32'h55;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle();
    check("mrst_push_acc", 64'(acc), 64'd1);
    bus.i_push_valid = 1'b0;
    lat = 0;
    while (!bus.o_pop_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check("mrst_latency", 64'(lat), 64'(LAT_EXP));
    bus.i_pop_ready = 1'b1;
    cycle();
    bus.i_pop_ready = 1'b0;
    first = (popped.size() > 0) ? popped[0] : 'x;
    check("mrst_pop_data55", 64'(first), 64'h55);
    check("mrst_end_empty", 64'(bus.o_empty), 64'd1);

`ifdef FIFO_BYPASS_EN
    bus.i_push_valid = 1'b1;
    bus.i_push_data  = 32'h1234;
    #1;
    check("byp_push_ready", 64'(bus.o_push_ready), 64'd1);
    check("byp_no_cen",     64'(bus.o_mem_cen),    64'd0);
    cycle();
    check("byp_acc", 64'(acc), 64'd1);
    bus.i_push_valid = 1'b0;
    check("byp_pop_valid", 64'(bus.o_pop_valid), 64'd1);
    check("byp_pop_data",  64'(bus.o_pop_data),  64'h1234);
    check("byp_count",     64'(bus.o_count),     64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
